// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns raw PS/2 set-2 scan bytes into an ordered table of currently held keys.
//   E0 (extended) and F0 (break) prefixes are decoded by a small prefix FSM.
//   Every change to the table is reported as a one-cycle event. A press that
//   arrives while the table is full sets a sticky overflow flag.
//
// Parameters
//   NUM_SLOTS       maximum number of simultaneously held keys (>= 1)
//   TIMEOUT_CYCLES  cycles a partial prefix sequence may wait for its next byte (>= 2)
//
// Ports
//   Clk           system clock, the only clock
//   Reset         synchronous active-high reset; overrides every other input
//   scan_byte     scan byte from the keyboard driver
//   scan_valid    one-cycle strobe that marks scan_byte as a new byte
//   overflow_clr  clears the sticky overflow flag
//   keys_out      held key codes; slot i = [8i+7:8i]; slot 0 is the oldest; an empty slot reads 8'h00
//   ext_out       bit i is set when slot i holds an E0-extended key
//   count_out     number of occupied slots
//   overflow      sticky flag: a make was dropped because the table was full
//   evt_valid     one-cycle pulse in the cycle after the table changes
//   evt_make      1 = a key was added, 0 = a key was removed
//   evt_code      code of the key that was added or removed
//   evt_ext       extended flag of the key that was added or removed
module ps2_key_tracker #(
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int CW            = $clog2(NUM_SLOTS + 1)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [7:0]             scan_byte,
  input  logic                   scan_valid,
  input  logic                   overflow_clr,
  output logic [8*NUM_SLOTS-1:0] keys_out,
  output logic [NUM_SLOTS-1:0]   ext_out,
  output logic [CW-1:0]          count_out,
  output logic                   overflow,
  output logic                   evt_valid,
  output logic                   evt_make,
  output logic [7:0]             evt_code,
  output logic                   evt_ext
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(NUM_SLOTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  // Prefix FSM and timeout
  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Key table
  logic [7:0]       keys_q [NUM_SLOTS];
  logic [7:0]       keys_d [NUM_SLOTS];
  logic             ext_q  [NUM_SLOTS];
  logic             ext_d  [NUM_SLOTS];
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  // Event outputs
  logic             evt_valid_q, evt_valid_d;
  logic             evt_make_q, evt_make_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic             evt_ext_q, evt_ext_d;

  // Decoded actions leaving the FSM
  logic             byte_ignored;
  logic             byte_accept;
  logic             act_make;
  logic             act_break;
  logic             act_ext;

  // Table lookup helpers
  logic             hit;
  int               hit_idx;
  logic             drop;

  // Keyboard self-test / ack / resend / error bytes never take part in a
  // sequence and must not refresh the timeout either.
  assign byte_ignored = (scan_byte == 8'h00) || (scan_byte == 8'hAA) ||
                        (scan_byte == 8'hFA) || (scan_byte == 8'hFE);
  assign byte_accept  = scan_valid && !byte_ignored;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    act_make  = 1'b0;
    act_break = 1'b0;
    act_ext   = 1'b0;

    if (byte_accept) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (scan_byte == 8'hE0)      state_d = S_EXT;
          else if (scan_byte == 8'hF0) state_d = S_BRK;
          else                         act_make = 1'b1;
        end
        S_EXT: begin
          if (scan_byte == 8'hF0)      state_d = S_EXT_BRK;
          else if (scan_byte == 8'hE0) state_d = S_EXT;
          else begin
            act_make = 1'b1;
            act_ext  = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          // A stray E0 after F0 restarts the sequence as an extended one.
          if (scan_byte == 8'hF0)      state_d = S_BRK;
          else if (scan_byte == 8'hE0) state_d = S_EXT;
          else begin
            act_break = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if ((scan_byte == 8'hE0) || (scan_byte == 8'hF0)) state_d = S_EXT_BRK;
          else begin
            act_break = 1'b1;
            act_ext   = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // A strobe in the expiry cycle takes the branch above, so it still
      // completes the sequence instead of being lost to the timeout.
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // Lookup: a key matches only on code and extended flag together.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit && (i < int'(count_q)) && (keys_q[i] == scan_byte) && (ext_q[i] == act_ext)) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      keys_d[i] = keys_q[i];
      ext_d[i]  = ext_q[i];
    end
    count_d     = count_q;
    drop        = 1'b0;
    evt_valid_d = 1'b0;
    evt_make_d  = 1'b0;
    evt_code_d  = 8'h00;
    evt_ext_d   = 1'b0;

    if (act_make && !hit) begin
      if (count_q == FULL_CNT) begin
        drop = 1'b1;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (i == int'(count_q)) begin
            keys_d[i] = scan_byte;
            ext_d[i]  = act_ext;
          end
        end
        count_d     = count_q + CW'(1);
        evt_valid_d = 1'b1;
        evt_make_d  = 1'b1;
        evt_code_d  = scan_byte;
        evt_ext_d   = act_ext;
      end
    end

    if (act_break && hit) begin
      // Close the gap so the remaining keys keep their press order.
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if ((i >= hit_idx) && (i < int'(count_q) - 1)) begin
          keys_d[i] = keys_q[i+1];
          ext_d[i]  = ext_q[i+1];
        end
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (i == int'(count_q) - 1) begin
          keys_d[i] = 8'h00;
          ext_d[i]  = 1'b0;
        end
      end
      count_d     = count_q - CW'(1);
      evt_valid_d = 1'b1;
      evt_make_d  = 1'b0;
      evt_code_d  = scan_byte;
      evt_ext_d   = act_ext;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_make_q  <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        keys_q[i] <= 8'h00;
        ext_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      evt_valid_q <= evt_valid_d;
      evt_make_q  <= evt_make_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        keys_q[i] <= keys_d[i];
        ext_q[i]  <= ext_d[i];
      end
    end
  end

  always_comb begin
    keys_out = '0;
    ext_out  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      keys_out[8*i +: 8] = keys_q[i];
      ext_out[i]         = ext_q[i];
    end
  end

  assign count_out = count_q;
  assign overflow  = overflow_q;
  assign evt_valid = evt_valid_q;
  assign evt_make  = evt_make_q;
  assign evt_code  = evt_code_q;
  assign evt_ext   = evt_ext_q;

endmodule
